// File: rtl/store_buffer.sv
// store_buffer: in-order store queue between the EX-stage store unit and data
// memory. Stores drain one at a time over the tagged-response bus. Loads probe
// the queue for same-cycle forwarding, or stall on a partial overlap.
//
// Handshake: a store transfers on a rising clock edge where st_valid and
// st_ready are both high. st_ready depends only on registered occupancy, never
// on st_valid or on the memory response, so a pop in the same cycle does not
// free a slot. On the memory side a request is offered while
// proc2Dmem_command==BUS_STORE. A nonzero Dmem2proc_response in that same cycle
// accepts it, and zero rejects it.
module store_buffer #(
  parameter int DEPTH     = 8,
  parameter int RETRY_GAP = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         st_valid,
  input  logic [31:0]                  st_addr,
  input  logic [31:0]                  st_data,
  input  logic [1:0]                   st_size,
  output logic                         st_ready,
  input  logic [31:0]                  ld_addr,
  input  logic                         ld_valid,
  output logic                         fwd_hit,
  output logic [31:0]                  fwd_data,
  output logic                         fwd_stall,
  output logic [1:0]                   proc2Dmem_command,
  output logic [31:0]                  proc2Dmem_addr,
  output logic [31:0]                  proc2Dmem_data,
  output logic [1:0]                   proc2Dmem_size,
  input  logic [3:0]                   Dmem2proc_response,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [1:0]                   dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int GAP_W = (RETRY_GAP < 1) ? 1 : $clog2(RETRY_GAP + 1);

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    BACKOFF = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic [31:0]      addr_q  [DEPTH];
  logic [31:0]      addr_d  [DEPTH];
  logic [31:0]      data_q  [DEPTH];
  logic [31:0]      data_d  [DEPTH];
  logic [1:0]       size_q  [DEPTH];
  logic [1:0]       size_d  [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;

  logic             do_enq;
  logic             do_pop;
  logic             head_live;
  logic             match_found;
  logic [PTR_W-1:0] match_idx;
  logic [PTR_W-1:0] slot;
  logic             ld_addr_unused;

  // Forwarding is whole-word, so the byte offset of the load never matters.
  assign ld_addr_unused = ^ld_addr[1:0];

  // Transfer qualifiers: accept on registered space, pop on an accepted request.
  always_comb begin
    do_enq = st_valid && (count_q < CNT_W'(DEPTH));
    do_pop = (state_q == REQ) && (Dmem2proc_response != 4'd0);
  end

  // Entry storage: write at tail on enqueue, invalidate head on pop.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    valid_d = valid_q;
    if (do_pop) begin
      valid_d[head_q] = 1'b0;
    end
    if (do_enq) begin
      addr_d[tail_q]  = st_addr;
      data_d[tail_q]  = st_data;
      size_d[tail_q]  = st_size;
      valid_d[tail_q] = 1'b1;
    end
  end

  // Pointers and occupancy. DEPTH is a power of two, so the wrap is natural.
  always_comb begin
    head_d  = do_pop ? head_q + PTR_W'(1) : head_q;
    tail_d  = do_enq ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q;
    case ({do_enq, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Drain FSM next state. The gap counter runs only in BACKOFF.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (count_d != '0) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (do_pop) begin
          if (count_d == '0) begin
            state_d = IDLE;
          end
        end else if (RETRY_GAP > 0) begin
          gap_d   = GAP_W'(RETRY_GAP);
          state_d = BACKOFF;
        end
      end
      BACKOFF: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q <= GAP_W'(1)) begin
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers. Reset drops any in-flight request and all pending stores.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      gap_q   <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        size_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
        size_q[i] <= size_d[i];
      end
    end
  end

  // Memory request and status outputs. Head fields read as zero when empty.
  always_comb begin
    head_live         = valid_q[head_q];
    proc2Dmem_command = (state_q == REQ) ? BUS_STORE : BUS_NONE;
    proc2Dmem_addr    = head_live ? addr_q[head_q] : 32'd0;
    proc2Dmem_data    = head_live ? data_q[head_q] : 32'd0;
    proc2Dmem_size    = head_live ? size_q[head_q] : 2'd0;
    st_ready          = (count_q < CNT_W'(DEPTH));
    empty             = (count_q == '0);
    count             = count_q;
    dbg_state         = 2'(state_q);
  end

  // Forwarding: walk oldest to youngest so the last match is the youngest.
  always_comb begin
    fwd_hit     = 1'b0;
    fwd_stall   = 1'b0;
    fwd_data    = 32'd0;
    match_found = 1'b0;
    match_idx   = '0;
    slot        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_q + PTR_W'(k);
      if (valid_q[slot] && (addr_q[slot][31:2] == ld_addr[31:2])) begin
        match_found = 1'b1;
        match_idx   = slot;
      end
    end
    if (ld_valid && match_found) begin
      if ((size_q[match_idx] == SIZE_WORD) && (addr_q[match_idx][1:0] == 2'b00)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[match_idx];
      end else begin
        fwd_stall = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed checks of the store buffer. The checks cover
// enqueue/drain order, retry backoff, full-buffer behaviour, forwarding, and
// asynchronous reset.
module tb_store_buffer;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_STORE = 2'd2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [1:0]  st_size = '0;
  logic        st_ready;
  logic [31:0] ld_addr = '0;
  logic        ld_valid = 1'b0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        fwd_stall;
  logic [1:0]  proc2Dmem_command;
  logic [31:0] proc2Dmem_addr;
  logic [31:0] proc2Dmem_data;
  logic [1:0]  proc2Dmem_size;
  logic [3:0]  resp = '0;
  logic        empty;
  logic [3:0]  count;
  logic [1:0]  dbg_state;

  int          n_checks = 0;
  int          n_errs   = 0;
  int          cyc_n    = 0;
  logic [63:0] exp_q[$];

  store_buffer #(.DEPTH(8), .RETRY_GAP(3)) dut (
    .clock              (clock),
    .reset              (reset),
    .st_valid           (st_valid),
    .st_addr            (st_addr),
    .st_data            (st_data),
    .st_size            (st_size),
    .st_ready           (st_ready),
    .ld_addr            (ld_addr),
    .ld_valid           (ld_valid),
    .fwd_hit            (fwd_hit),
    .fwd_data           (fwd_data),
    .fwd_stall          (fwd_stall),
    .proc2Dmem_command  (proc2Dmem_command),
    .proc2Dmem_addr     (proc2Dmem_addr),
    .proc2Dmem_data     (proc2Dmem_data),
    .proc2Dmem_size     (proc2Dmem_size),
    .Dmem2proc_response (resp),
    .empty              (empty),
    .count              (count),
    .dbg_state          (dbg_state)
  );

  // Clock and watchdog.
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    cyc_n++;
  endtask

  task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
    cyc();
    st_valid = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (proc2Dmem_command != BUS_STORE && n < 10) begin
      cyc();
      n++;
    end
    check_eq(tag, 32'(proc2Dmem_command), 32'(BUS_STORE));
  endtask

  // Accept every request and pop the scoreboard in order. The span from the
  // first STORE to the last is returned.
  task automatic drain_check(input string tag, input int budget, output int span);
    int n = 0;
    int first = -1;
    int last  = -1;
    logic [63:0] e;
    resp = 4'd1;
    while (exp_q.size() != 0 && n < budget) begin
      #1;
      if (proc2Dmem_command == BUS_STORE) begin
        e = exp_q.pop_front();
        check_eq({tag, "_addr"}, proc2Dmem_addr, e[63:32]);
        check_eq({tag, "_data"}, proc2Dmem_data, e[31:0]);
        if (first < 0) first = cyc_n;
        last = cyc_n;
      end
      cyc();
      n++;
    end
    check_eq({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    #1;
    check_eq({tag, "_empty"}, 32'(empty), 32'd1);
    span = last - first;
    resp = 4'd0;
  endtask

  initial begin
    int span;
    int stale;

    // Reset values.
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_cmd",    32'(proc2Dmem_command), 32'(BUS_NONE));
    check_eq("rst_addr",   proc2Dmem_addr, 32'd0);
    check_eq("rst_ready",  32'(st_ready), 32'd1);
    check_eq("rst_empty",  32'(empty), 32'd1);
    check_eq("rst_count",  32'(count), 32'd0);
    check_eq("rst_fwd",    32'({fwd_hit, fwd_stall}), 32'd0);
    reset = 1'b1;
    cyc();

    // Single store: request one cycle after enqueue, accepted at once.
    resp = 4'd1;
    st_valid = 1'b1; st_addr = 32'h100; st_data = 32'hDEADBEEF; st_size = 2'd2;
    #1;
    check_eq("t1_idle_cmd", 32'(proc2Dmem_command), 32'(BUS_NONE));
    cyc();
    st_valid = 1'b0;
    #1;
    check_eq("t1_cmd",  32'(proc2Dmem_command), 32'(BUS_STORE));
    check_eq("t1_addr", proc2Dmem_addr, 32'h100);
    check_eq("t1_data", proc2Dmem_data, 32'hDEADBEEF);
    check_eq("t1_size", 32'(proc2Dmem_size), 32'd2);
    cyc();
    #1;
    check_eq("t1_empty",    32'(empty), 32'd1);
    check_eq("t1_done_cmd", 32'(proc2Dmem_command), 32'(BUS_NONE));

    // Backoff: one rejection gives STORE, NONE x3, STORE on the same head.
    resp = 4'd0;
    push_store(32'h40, 32'h12345678, 2'd2);
    #1;
    check_eq("bo_store1", 32'(proc2Dmem_command), 32'(BUS_STORE));
    check_eq("bo_addr1",  proc2Dmem_addr, 32'h40);
    cyc(); #1;
    check_eq("bo_none1",  32'(proc2Dmem_command), 32'(BUS_NONE));
    check_eq("bo_state",  32'(dbg_state), 32'd2);
    cyc(); #1;
    check_eq("bo_none2",  32'(proc2Dmem_command), 32'(BUS_NONE));
    cyc(); #1;
    check_eq("bo_none3",  32'(proc2Dmem_command), 32'(BUS_NONE));
    resp = 4'd1;
    cyc(); #1;
    check_eq("bo_store2", 32'(proc2Dmem_command), 32'(BUS_STORE));
    check_eq("bo_addr2",  proc2Dmem_addr, 32'h40);
    cyc(); #1;
    check_eq("bo_empty",  32'(empty), 32'd1);
    resp = 4'd0;

    // Fill with memory rejecting. The tail pointer wraps inside the ring.
    for (int i = 0; i < 8; i++) begin
      push_store(32'(i * 4), 32'hA000_0000 + 32'(i), 2'd2);
      exp_q.push_back({32'(i * 4), 32'hA000_0000 + 32'(i)});
    end
    #1;
    check_eq("fill_ready", 32'(st_ready), 32'd0);
    check_eq("fill_count", 32'(count), 32'd8);
    drain_check("fill", 100, span);
    check_eq("fill_span", 32'(span), 32'd7);

    // Four more stores after the wrap keep their order.
    for (int i = 0; i < 4; i++) begin
      push_store(32'h80 + 32'(i * 4), 32'hB000_0000 + 32'(i), 2'd2);
      exp_q.push_back({32'h80 + 32'(i * 4), 32'hB000_0000 + 32'(i)});
    end
    check_eq("more_count", 32'(count), 32'd4);
    drain_check("more", 60, span);

    // Forwarding.
    push_store(32'h200, 32'h11111111, 2'd2);
    push_store(32'h200, 32'h22222222, 2'd2);
    ld_valid = 1'b1; ld_addr = 32'h200;
    #1;
    check_eq("fwd_word_hit",   32'(fwd_hit), 32'd1);
    check_eq("fwd_word_data",  fwd_data, 32'h22222222);
    check_eq("fwd_word_stall", 32'(fwd_stall), 32'd0);
    push_store(32'h201, 32'h00000033, 2'd0);
    ld_addr = 32'h200;
    #1;
    check_eq("fwd_byte_hit",   32'(fwd_hit), 32'd0);
    check_eq("fwd_byte_stall", 32'(fwd_stall), 32'd1);
    ld_addr = 32'h300;
    #1;
    check_eq("fwd_miss", {fwd_data[29:0], fwd_hit, fwd_stall}, 32'd0);
    st_valid = 1'b1; st_addr = 32'h300; st_data = 32'h44444444; st_size = 2'd2;
    #1;
    check_eq("fwd_same_cycle", 32'(fwd_hit), 32'd0);
    cyc();
    st_valid = 1'b0;
    #1;
    check_eq("fwd_next_hit",  32'(fwd_hit), 32'd1);
    check_eq("fwd_next_data", fwd_data, 32'h44444444);
    ld_valid = 1'b0;
    #1;
    check_eq("fwd_off", {fwd_data[29:0], fwd_hit, fwd_stall}, 32'd0);
    exp_q.push_back({32'h200, 32'h11111111});
    exp_q.push_back({32'h200, 32'h22222222});
    exp_q.push_back({32'h201, 32'h00000033});
    exp_q.push_back({32'h300, 32'h44444444});
    drain_check("fwd", 60, span);

    // Full buffer: a pop and a new store in the same cycle.
    for (int i = 0; i < 8; i++) begin
      push_store(32'h600 + 32'(i * 4), 32'hC0 + 32'(i), 2'd2);
    end
    wait_req("sim_req_seen");
    resp = 4'd1;
    st_valid = 1'b1; st_addr = 32'h7FC; st_data = 32'h00000BAD; st_size = 2'd2;
    #1;
    check_eq("sim_ready", 32'(st_ready), 32'd0);
    check_eq("sim_count", 32'(count), 32'd8);
    $display("note: upstream offered a store while full; it is dropped");
    cyc();
    st_valid = 1'b0;
    resp = 4'd0;
    #1;
    check_eq("sim_count_after", 32'(count), 32'd7);
    check_eq("sim_ready_after", 32'(st_ready), 32'd1);
    for (int i = 1; i < 8; i++) begin
      exp_q.push_back({32'h600 + 32'(i * 4), 32'hC0 + 32'(i)});
    end
    drain_check("sim", 80, span);

    // Asynchronous reset mid-request with five stores pending.
    for (int i = 0; i < 5; i++) begin
      push_store(32'h800 + 32'(i * 4), 32'hD0 + 32'(i), 2'd2);
    end
    wait_req("ar_req_seen");
    check_eq("ar_count_pre", 32'(count), 32'd5);
    #1;
    reset = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h800;
    #1;
    check_eq("ar_cmd",   32'(proc2Dmem_command), 32'(BUS_NONE));
    check_eq("ar_addr",  proc2Dmem_addr, 32'd0);
    check_eq("ar_data",  proc2Dmem_data, 32'd0);
    check_eq("ar_size",  32'(proc2Dmem_size), 32'd0);
    check_eq("ar_empty", 32'(empty), 32'd1);
    check_eq("ar_count", 32'(count), 32'd0);
    check_eq("ar_ready", 32'(st_ready), 32'd1);
    check_eq("ar_fwd",   32'({fwd_hit, fwd_stall}), 32'd0);
    cyc();
    reset = 1'b1;
    resp = 4'd1;
    ld_valid = 1'b0;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (proc2Dmem_command == BUS_STORE) stale++;
      cyc();
    end
    check_eq("ar_no_stale", 32'(stale), 32'd0);
    push_store(32'h500, 32'h55555555, 2'd2);
    #1;
    check_eq("ar_post_cmd",  32'(proc2Dmem_command), 32'(BUS_STORE));
    check_eq("ar_post_addr", proc2Dmem_addr, 32'h500);
    cyc(); #1;
    check_eq("ar_post_empty", 32'(empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits directly downstream of the EX-stage store address/data unit.
- Accepts one store per cycle (address, data, size), queues stores in program order in a circular FIFO, and drains them one at a time to data memory over the tagged-response bus.
- Provides same-cycle store-to-load forwarding for the load path, and signals a stall when a pending store partially overlaps a load.

Parameters:
- DEPTH, 8, number of store entries; power of two, ≥2.
- RETRY_GAP, 3, idle cycles inserted after memory rejects a request (response tag 0) before re-issuing it.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-low reset (reset==0 clears the block)
- st_valid  in  1  store presented by EX this cycle
- st_addr  in  32  store byte address
- st_data  in  32  store data, right-aligned
- st_size  in  2  MEM_SIZE: 0 BYTE, 1 HALF, 2 WORD
- st_ready  out  1  buffer can accept a store this cycle
- ld_addr  in  32  load address probed for forwarding
- ld_valid  in  1  load probe active
- fwd_hit  out  1  forwarded data valid
- fwd_data  out  32  forwarded word
- fwd_stall  out  1  overlap that cannot be forwarded; load must wait
- proc2Dmem_command  out  2  BUS_NONE(0) / BUS_STORE(2)
- proc2Dmem_addr  out  32  head entry address
- proc2Dmem_data  out  32  head entry data
- proc2Dmem_size  out  2  head entry size
- Dmem2proc_response  in  4  nonzero = request accepted; 0 = rejected
- empty  out  1  no stores pending
- count  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- Reset (async, reset==0): head=tail=count=0, FSM=IDLE, all entries invalid. Outputs: proc2Dmem_command=BUS_NONE, addr/data/size=0, st_ready=1, empty=1, fwd_hit=0, fwd_stall=0.
- Enqueue:
  - st_ready = (registered count < DEPTH). It is not relieved by a same-cycle dequeue.
  - On st_valid && st_ready, write to entry[tail]; tail advances mod DEPTH at the clock edge.
  - st_valid while full is dropped. The bench flags this as a protocol error in the upstream stage.
- FSM states IDLE, REQ, BACKOFF:
  - IDLE: command=BUS_NONE. Go to REQ the cycle after count becomes nonzero. The entry is registered, so there is no same-cycle bypass: enqueue-to-first-request latency is 1 cycle.
  - REQ: command=BUS_STORE with the head entry fields driven. If response≠0, pop head (head+1 mod DEPTH, count−1); stay in REQ if count−1>0, else go to IDLE. If response==0, load the gap counter with RETRY_GAP and go to BACKOFF.
  - BACKOFF: command=BUS_NONE. Decrement the counter each cycle; at 0, return to REQ on the same head entry. Enqueues continue during BACKOFF.
- Simultaneous enqueue and pop: count unchanged; head and tail both advance; wrap-around mod DEPTH is handled independently for each pointer.
- Output timing: proc2Dmem_* are combinational from head entry + FSM state. Outside REQ, addr/data/size hold the head entry values (0 when empty).
- Forwarding (combinational; considers valid entries only, youngest first):
  - A match means entry addr[31:2] == ld_addr[31:2].
  - Youngest match is size WORD with addr[1:0]==0: fwd_hit=1, fwd_data=entry data.
  - Youngest match is BYTE or HALF: fwd_hit=0, fwd_stall=1.
  - No match, or ld_valid==0: fwd_hit=0, fwd_stall=0, fwd_data=0.
  - The entry being popped this cycle still participates. A store enqueued this cycle does not participate.
- Reset mid-operation: an in-flight REQ is abandoned and all pending stores are discarded. The memory side must tolerate a dropped request.
- empty = (count==0). count saturates at DEPTH by construction.

Test Plan:
- Single store: enqueue addr 0x100, data 0xDEADBEEF, WORD; response=1 on first REQ cycle -> BUS_STORE seen exactly 1 cycle after enqueue with those values; then empty=1 and command=BUS_NONE.
- Fill and wrap: 8 back-to-back stores to 0x0..0x1C with response held 0 (rejected) -> st_ready=0 after the 8th. Then response=1 -> 8 requests issued in order, one per REQ cycle, with 3 BUS_NONE cycles after each rejection. Then enqueue 4 more -> pointers wrap and order is preserved.
- Backoff: response=0 once, then 1 -> command pattern STORE, NONE, NONE, NONE, STORE, with the same addr on both STOREs.
- Forwarding: stores WORD 0x200=0x11111111, then WORD 0x200=0x22222222; probe 0x200 -> fwd_hit=1, fwd_data=0x22222222. Then BYTE store to 0x201 and probe 0x200 -> fwd_hit=0, fwd_stall=1. Probe 0x300 -> all 0.
- Simultaneous: full buffer; pop and st_valid in the same cycle -> the new store is rejected (st_ready=0) and count goes 8→7. Next cycle st_ready=1.
- Async reset asserted mid-REQ with 5 entries pending -> outputs go to reset values immediately, without waiting for a clock edge. After release, no stale stores are issued.
